// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hcount/vcount, sync, blank,
// line/frame strobes and a completed-frame counter.
module video_timing_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int HCOUNT_W  = 11,
    parameter int VCOUNT_W  = 10,
    parameter int FRAME_W   = 8
) (
    input  logic                vclock,
    input  logic                reset,
    input  logic                ce,
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                hsync,
    output logic                vsync,
    output logic                blank,
    output logic                line_start,
    output logic                frame_start,
    output logic [FRAME_W-1:0]  frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [HCOUNT_W-1:0] H_ACT  = HCOUNT_W'(H_ACTIVE);
    localparam logic [HCOUNT_W-1:0] HS_BEG = HCOUNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCOUNT_W-1:0] HS_END = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_ACT  = VCOUNT_W'(V_ACTIVE);
    localparam logic [VCOUNT_W-1:0] VS_BEG = VCOUNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCOUNT_W-1:0] VS_END = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic                h_wrap;
    logic                v_wrap;
    logic [HCOUNT_W-1:0] h_nxt;
    logic [VCOUNT_W-1:0] v_nxt;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_nxt  = h_wrap ? '0 : hcount + 1'b1;
        v_nxt  = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount + 1'b1;
        end
    end

    // Decode from the next counter values so every registered output
    // lines up with the counters it is presented alongside.
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                hcount      <= h_nxt;
                vcount      <= v_nxt;
                blank       <= (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
                hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END)
                               ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END)
                               ? VSYNC_POL : ~VSYNC_POL;
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed-mode XVGA/VGA counters.
- Display mode is set by porch/sync/active parameters. Adds sync polarity selection, pixel clock-enable, line/frame strobes and a frame counter.
- Sits at the head of the display path and drives hcount/vcount/blank/sync into pixel generators and the VGA output stage.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, hsync level while in sync pulse (0 = active low)
- VSYNC_POL, 0, vsync level while in sync pulse
- HCOUNT_W, 11, hcount width; must hold H_TOTAL-1
- VCOUNT_W, 10, vcount width; must hold V_TOTAL-1
- FRAME_W, 8, frame counter width

Ports:
- vclock  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high
- ce  in  1  pixel advance enable; tie high for one pixel per clock
- hcount  out  HCOUNT_W  pixel index on current line
- vcount  out  VCOUNT_W  line index
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- blank  out  1  high outside the active area
- line_start  out  1  one-clock pulse at hcount==0
- frame_start  out  1  one-clock pulse at hcount==0 && vcount==0
- frame_count  out  FRAME_W  completed-frame counter

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 1344 x 806.
- Region order per line and per frame: active, front porch, sync, back porch.
- All outputs are registered. Each output is a pure function of the hcount/vcount presented in the same cycle; there is no lag between the counters and the decoded signals.
- blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE).
- hsync = HSYNC_POL while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; otherwise ~HSYNC_POL.
- vsync = VSYNC_POL while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, for every hcount of those lines; otherwise ~VSYNC_POL.
- Advance: on a vclock edge with ce=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - On the hcount wrap, vcount increments; at V_TOTAL-1 it wraps to 0.
- Hold: ce=0 freezes hcount, vcount, hsync, vsync, blank and frame_count.
- line_start is 1 in exactly the one clock following a ce edge that moved hcount to 0. It is 0 on the next clock regardless of ce.
- frame_start is the same, for a ce edge that moved the counters to (0,0).
- frame_count increments, modulo 2^FRAME_W, on the same edge that raises frame_start.
- Reset (async, takes effect immediately, including mid-line or mid-sync):
  - hcount=0, vcount=0, blank=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - line_start=0, frame_start=0, frame_count=0.
- After reset release, the first strobes occur at the first wrap to hcount==0 (line) and to (0,0) (frame). The reset state itself produces no strobe.
- ce may toggle arbitrarily. Wrap and strobe decisions use only the counter values at the enabled edge.
- Mode parameters with any porch or sync width of 0 are unsupported. Widths too small for the totals are unsupported.

Test Plan:
- Small mode (H 8/2/3/3 → total 16; V 4/1/2/1 → total 8), ce=1:
  - hcount cycles 0..15.
  - blank rises at hcount 8 and falls at 0.
  - hsync is low for hcount 10..12.
  - vcount steps 0..7; vsync is low for lines 5..6.
- Same mode, 3 full frames:
  - frame_start high exactly at 128-clock spacing; frame_count = 3.
  - line_start high every 16 clocks.
  - No strobe in the cycle immediately after reset release.
- HSYNC_POL=1, VSYNC_POL=1: sync levels inverted versus the first scenario; blank timing unchanged.
- ce high every third clock: all outputs change only one clock after ce-high edges. Strobes are exactly one clock wide, and there are 384 clocks per frame.
- Reset asserted at hcount=11, vcount=5, mid-sync: outputs immediately return to reset values without waiting for a clock edge. After release, the counters count up from 0.
- Defaults (1344x806): hsync low for hcount 1048..1183; vsync low for lines 771..776; frame_start period of 1083264 clocks.
